// File: rtl/fixed_point_pkg.sv
// Shared types and arithmetic helpers for the fixed-point frame accumulator.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand container for the width-generic helpers; callers sign-extend into it.
  localparam int OP_W = 32;
  localparam logic signed [OP_W:0] ONE_W = 33'sd1;

  function automatic logic signed [OP_W:0] max_val(input int width);
    return (ONE_W <<< (width - 1)) - ONE_W;
  endfunction

  function automatic logic signed [OP_W:0] min_val(input int width);
    return -(ONE_W <<< (width - 1));
  endfunction

  // Returns {ovf, sum}: sum clamped to the signed range of 'width' bits.
  function automatic logic [OP_W:0] sat_add(input logic signed [OP_W-1:0] a,
                                            input logic signed [OP_W-1:0] b,
                                            input int width);
    logic signed [OP_W:0] s;
    logic signed [OP_W:0] r;
    logic                 ovf;
    s   = {a[OP_W-1], a} + {b[OP_W-1], b};
    ovf = (s > max_val(width)) || (s < min_val(width));
    r   = s;
    if (s > max_val(width))      r = max_val(width);
    else if (s < min_val(width)) r = min_val(width);
    return {ovf, r[OP_W-1:0]};
  endfunction

endpackage

// File: rtl/fixed_point_acc_if.sv
// Sample stream in / frame result out bundle for fixed_point_acc.
interface fixed_point_acc_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic signed [WIDTH-1:0] VALUE_IN;
  logic                    VALID_IN;
  logic                    OVERFLOW_IN;
  logic                    LAST_IN;
  logic                    READY_IN;
  logic signed [WIDTH-1:0] ACC_OUT;
  logic                    VALID_OUT;
  logic [CNT_W-1:0]        COUNT_OUT;
  logic                    OVERFLOW_OUT;
  logic                    DROP_OUT;

  modport master (
    output VALUE_IN, VALID_IN, OVERFLOW_IN, LAST_IN, READY_IN,
    input  ACC_OUT, VALID_OUT, COUNT_OUT, OVERFLOW_OUT, DROP_OUT
  );

  modport slave (
    input  VALUE_IN, VALID_IN, OVERFLOW_IN, LAST_IN, READY_IN,
    output ACC_OUT, VALID_OUT, COUNT_OUT, OVERFLOW_OUT, DROP_OUT
  );
endinterface

// File: rtl/fixed_point_acc.sv
// Frame accumulator: sums a sample frame and holds the total under valid/ready.
// Build option FIXED_POINT_ACC_SAT_EN: saturate the running sum instead of wrapping.
module fixed_point_acc
  import fixed_point_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input logic               CLK,
  input logic               RSTN,
  fixed_point_acc_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t                  state, state_n;
  logic signed [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    ovf, ovf_n;
  logic                    drop, drop_n;

  logic [OP_W:0]           add_r;
  logic                    add_ovf;
  logic signed [WIDTH-1:0] add_sum;
  logic                    load;

  assign add_r   = sat_add(OP_W'(acc), OP_W'(bus.VALUE_IN), WIDTH);
  assign add_ovf = add_r[OP_W];

`ifdef FIXED_POINT_ACC_SAT_EN
  logic unused_hi;
  assign unused_hi = ^add_r[OP_W-1:WIDTH];
  assign add_sum   = add_r[WIDTH-1:0];
`else
  logic unused_sum;
  assign unused_sum = ^add_r[OP_W-1:0];
  assign add_sum    = acc + bus.VALUE_IN;
`endif

  // A frame opens from IDLE, or from DONE in the very cycle its result is taken.
  assign load = bus.VALID_IN &&
                ((state == IDLE) || ((state == DONE) && bus.READY_IN));

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    drop_n  = 1'b0;
    if (load) begin
      acc_n   = bus.VALUE_IN;
      cnt_n   = CNT_W'(1);
      ovf_n   = bus.OVERFLOW_IN;
      state_n = (bus.LAST_IN || (MAX_LEN == 1)) ? DONE : ACC;
    end else begin
      case (state)
        ACC: begin
          if (bus.VALID_IN) begin
            acc_n = add_sum;
            cnt_n = cnt + 1'b1;
            ovf_n = ovf | bus.OVERFLOW_IN | add_ovf;
            if (bus.LAST_IN || (cnt_n == CNT_W'(MAX_LEN))) state_n = DONE;
          end
        end
        DONE: begin
          if (bus.READY_IN)      state_n = IDLE;
          else if (bus.VALID_IN) drop_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      drop  <= drop_n;
    end
  end

  assign bus.ACC_OUT      = acc;
  assign bus.VALID_OUT    = (state == DONE);
  assign bus.COUNT_OUT    = cnt;
  assign bus.OVERFLOW_OUT = ovf;
  assign bus.DROP_OUT     = drop;

endmodule
